mult_seq_ctrl: RTL and testbench
================================

// Module: mult_seq_ctrl
// PURPOSE
//  Sequencer for the 32-bit unsigned shift-add multiplier of the single-cycle CPU.
//  Accepts a start request from the EX stage and latches the operands.
//  Performs one add-and-shift step per clock for WIDTH clocks.
//  Publishes the 64-bit product as HI/LO registers, with busy/done so the CPU can stall until the result is ready.
// PARAMETERS
//  WIDTH   32  operand width; product is 2*WIDTH bits
//  CNT_W   6   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk     in   1        single clock, all state updates on posedge
//  reset   in   1        synchronous, active-high; sampled on posedge clk
//  start   in   1        request; sampled only in IDLE
//  op      in   3        function code: 3'b000 MULTU, 3'b111 CLRHL, others no-op
//  a       in   WIDTH    multiplicand, sampled with start
//  b       in   WIDTH    multiplier, sampled with start
//  busy    out  1        high in RUN and DONE
//  done    out  1        one-cycle pulse when hi/lo hold a new product
//  hi      out  WIDTH    product[2*WIDTH-1:WIDTH], registered
//  lo      out  WIDTH    product[WIDTH-1:0], registered
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, hi=0, lo=0.
//   Internal mcand, mplier, acc and cnt are cleared.
//   Reset wins over every other input, including in mid-RUN; the partial product is discarded.
//  FSM states: IDLE, RUN, DONE.
//  IDLE, start=1, op=000:
//   - mcand <= {WIDTH'b0,a}; mplier <= b; acc <= 0; cnt <= 0
//   - next state RUN
//  IDLE, start=1, op=111:
//   - hi <= 0, lo <= 0; stay in IDLE; no done pulse
//  IDLE, start=1, other op: ignored.  IDLE, start=0: hold.
//  RUN, every cycle:
//   - if mplier[0]: acc <= acc + mcand, mod 2**(2*WIDTH) (never overflows for unsigned operands)
//   - mcand <= mcand << 1; mplier <= mplier >> 1; cnt <= cnt + 1
//   - when cnt == WIDTH-1, this cycle is the final step; next state DONE
//   - start is ignored in RUN; there is no queueing and no abort input
//  DONE:
//   - {hi,lo} <= acc; done=1 for exactly this cycle; next state IDLE
//   - a start in this cycle is ignored; the requester re-asserts it in IDLE
//  Latency:
//   - start sampled at edge T; RUN spans T+1..T+WIDTH; DONE at T+WIDTH+1
//   - hi/lo valid from edge T+WIDTH+2
//   - back-to-back issue interval is WIDTH+2 cycles
//  Outputs:
//   - busy = (state != IDLE)
//   - done is registered-decoded from state; no combinational path from start
//  hi/lo are held between operations and change only on DONE, CLRHL, or reset.
//  Operand zero needs no early exit: the full WIDTH steps always run, so latency is fixed.
// STRUCTURE
//  Shared package mult_pkg:
//   - op codes OP_MULTU=3'b000, OP_CLRHL=3'b111
//   - state encoding S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2
//   - default WIDTH
//  One sub-module, mult_step (combinational):
//   - inputs acc, mcand, mplier_lsb; output acc_next
//   - the 64-bit conditional adder, the AND-gated partial product plus add
//  mult_seq_ctrl owns the FSM, counter, shift registers, and HI/LO.
// TESTING
//  1. reset for 2 cycles, then idle 5 cycles -> busy=0, done=0, hi=0, lo=0 throughout.
//  2. start, op=000, a=7, b=6
//     -> busy next cycle; done exactly 33 cycles after the start edge; hi=0, lo=42.
//  3. a=32'hFFFFFFFF, b=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001.
//  4. a=32'h12345678, b=0 -> full latency kept, hi=0, lo=0.
//  5. start pulsed again mid-RUN with different operands
//     -> ignored; the result is the first product; one done pulse only.
//  6. reset asserted at RUN cycle 10 of a=3, b=5
//     -> IDLE next cycle, hi/lo=0, no done.
//     Then CLRHL after a completed 3*5 -> lo returns to 0 with no done.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: function codes,
// FSM state encoding and the default operand width.
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_CLRHL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add step: adds the shifted multiplicand into the accumulator when
// the current multiplier bit is set.
module mult_step #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic               mplier_lsb,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [2*WIDTH-1:0] partial;

    assign partial  = mcand & {(2*WIDTH){mplier_lsb}};
    assign acc_next = acc + partial;

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequencer for the unsigned shift-add multiplier: latches operands on start,
// runs WIDTH add/shift steps, then publishes the product on hi/lo.
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Handshake: start/op/a/b are taken only on an edge where busy=0; while
    // busy=1 start is ignored. done pulses for one cycle and hi/lo carry the
    // new product from the following edge onward.

    state_t             state, state_next;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   cnt;
    logic               last_step;
    logic               take_mult;
    logic               take_clr;

    assign last_step = (cnt == CNT_W'(WIDTH - 1));
    assign take_mult = start && (op == OP_MULTU);
    assign take_clr  = start && (op == OP_CLRHL);
    assign busy      = (state != S_IDLE);

    mult_step #(.WIDTH(WIDTH)) u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier_lsb (mplier[0]),
        .acc_next   (acc_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (take_mult) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (last_step) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: reset discards any partial product; hi/lo move only on DONE or CLRHL.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (take_mult) begin
                        mcand  <= {{WIDTH{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end else if (take_clr) begin
                        hi <= '0;
                        lo <= '0;
                    end
                end
                S_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                S_DONE: begin
                    hi <= acc[2*WIDTH-1:WIDTH];
                    lo <= acc[WIDTH-1:0];
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Bench for mult_seq_ctrl: a driver issues directed and random requests, a
// reference model predicts products and timing, a monitor checks every cycle.
module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    mult_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // cyc = number of rising edges so far; the cycle after edge k has cyc == k
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model and scoreboard
    logic [2*W-1:0] exp_q[$];
    int             exp_cyc_q[$];
    int             busy_end = -1;
    int             apply_at = -1;
    logic [2*W-1:0] pending = '0;
    logic [2*W-1:0] model_hilo = '0;
    bit             mon_en = 1'b0;
    int             n_cmp = 0;
    int             n_bad = 0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, expv);
        end
    endtask

    task automatic model_flush();
        exp_q.delete();
        exp_cyc_q.delete();
        busy_end   = -1;
        apply_at   = -1;
        model_hilo = '0;
    endtask

    // driver tasks
    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            model_flush();
            mon_en = 1'b1;
        end
        reset = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        // accepted only if the model was idle in the cycle before this edge
        if (cyc - 1 > busy_end) begin
            if (o == 3'b000) begin
                exp_q.push_back({{W{1'b0}}, x} * {{W{1'b0}}, y});
                exp_cyc_q.push_back(cyc + W);
                busy_end = cyc + W;
            end else if (o == 3'b111) begin
                model_hilo = '0;
            end
        end
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (cyc <= busy_end && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor
    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_done;
            exp_done = (exp_cyc_q.size() != 0) && (exp_cyc_q[0] == cyc);
            check("busy", 2*W'(busy), 2*W'(cyc <= busy_end));
            check("done", 2*W'(done), 2*W'(exp_done));
            if (exp_done) begin
                pending  = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                apply_at = cyc + 1;
            end
            if (cyc == apply_at) begin
                model_hilo = pending;
            end
            check("hilo", {hi, lo}, model_hilo);
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;

        // reset then idle
        do_reset(2);
        idle(5);

        // directed products
        issue(3'b000, 32'd7, 32'd6);
        wait_idle();
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();
        issue(3'b000, 32'h12345678, 32'h0);
        wait_idle();

        // start during RUN with other operands is ignored
        issue(3'b000, 32'd1000, 32'd77);
        idle(5);
        issue(3'b000, 32'd5, 32'd9);
        idle(10);
        issue(3'b111, 32'd0, 32'd0);
        wait_idle();

        // reset in the middle of a run discards the product
        issue(3'b000, 32'd3, 32'd5);
        idle(9);
        do_reset(1);
        idle(3);

        // CLRHL after a completed product
        issue(3'b000, 32'd3, 32'd5);
        wait_idle();
        idle(2);
        issue(3'b111, 32'hDEAD, 32'hBEEF);
        idle(3);
        issue(3'b010, 32'd9, 32'd9);
        idle(3);

        // randomized traffic
        for (int i = 0; i < 30; i++) begin
            int r;
            logic [2:0] o;
            logic [W-1:0] x;
            logic [W-1:0] y;
            r = $urandom_range(0, 9);
            if (r < 7)       o = 3'b000;
            else if (r == 7) o = 3'b111;
            else             o = 3'($urandom_range(1, 6));
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 5) == 0) x = '1;
            if ($urandom_range(0, 5) == 0) y = '0;
            issue(o, x, y);
            if (o == 3'b000 && $urandom_range(0, 2) == 0) begin
                idle($urandom_range(1, 30));
                issue(3'b000, $urandom, $urandom);
            end
            wait_idle();
            idle($urandom_range(0, 3));
        end

        idle(5);
        check("queue_empty", 2*W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
